write_buffer: RTL
=================

WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered write-back lines (power of two, >=2).
REQ-002 Parameter PTR_W, default 2, log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 proc_reset  input  1  synchronous, active-high reset.
REQ-005 c_read  input  1  cache line-read request; held high until c_ready is seen.
REQ-006 c_write  input  1  cache line-write-back request; held high until c_ready is seen.
REQ-007 c_addr  input  28  line address (word address bits 29:2).
REQ-008 c_wdata  input  128  write-back line data.
REQ-009 c_rdata  output  128  read line data, valid in the c_ready cycle of a read.
REQ-010 c_ready  output  1  registered one-cycle completion pulse toward the cache.
REQ-011 mem_read / mem_write  output  1 each  memory requests, registered.
REQ-012 mem_addr  output  28; mem_wdata  output  128  memory request address and data, registered.
REQ-013 mem_rdata  input  128; mem_ready  input  1  memory data and one-cycle completion pulse.
REQ-014 wb_count  output  PTR_W+1  number of occupied entries; wb_empty  output  1  wb_count==0.

Function
REQ-015 Buffer SHALL be a circular FIFO of DEPTH entries {valid, addr[27:0], data[127:0]} with head/tail pointers wrapping modulo DEPTH.
REQ-016 c_ready SHALL have no combinational path from any input; each cache request SHALL get exactly one c_ready pulse, and no new request SHALL be sampled in the c_ready cycle.
REQ-017 Write: when c_write=1, c_ready=0 and a coalesce target exists, SHALL overwrite that entry's data at the edge; c_ready=1 next cycle.
REQ-018 Coalesce target: youngest valid entry with addr==c_addr that is not currently in flight to memory.
REQ-019 Write without coalesce target: if wb_count<DEPTH (registered value), SHALL push at tail and pulse c_ready next cycle; if full, SHALL stall (c_ready=0) until a pop frees space.
REQ-020 Push and pop in the same cycle SHALL both take effect; wb_count unchanged.
REQ-021 Read forward: when c_read=1 and any valid entry (including the in-flight entry) matches c_addr, SHALL load c_rdata from the youngest match and pulse c_ready next cycle; no memory access.
REQ-022 Read miss: SHALL issue mem_read with mem_addr=c_addr once the memory port is idle; on mem_ready SHALL register mem_rdata into c_rdata and pulse c_ready next cycle.
REQ-023 Memory port FSM: M_IDLE, M_RD, M_WR. M_IDLE->M_RD on pending read miss (priority); M_IDLE->M_WR when buffer non-empty and no read miss pending; M_RD/M_WR->M_IDLE on mem_ready.
REQ-024 A read miss arriving during M_WR SHALL wait for that write to complete; reads SHALL bypass older non-matching buffered writes.
REQ-025 M_WR SHALL drive the head entry's addr and data, mark it in flight, and pop it on mem_ready.
REQ-026 mem_read/mem_write SHALL stay high until mem_ready is sampled, drop the following cycle, and stay low for at least one cycle between transactions; never both high.
REQ-027 If c_read and c_write are both high, the write SHALL be serviced first.
REQ-028 Throughput: write to non-full buffer or read forward completes 2 cycles after the request is raised; a read miss takes memory latency +2.

Reset
REQ-029 On proc_reset: all entries invalid, pointers 0, wb_count=0, wb_empty=1, FSM=M_IDLE, c_ready=0, mem_read=mem_write=0, c_rdata=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset mid-transaction SHALL abandon any outstanding memory request and buffered data without a further c_ready pulse.

Verification
REQ-031 Write addr 0x0000010 data D1 into empty buffer, memory stalled -> c_ready next cycle, wb_count=1, then mem_write with addr 0x0000010, data D1; pop on mem_ready -> wb_empty=1.
REQ-032 Four writes to distinct addrs, memory stalled, then fifth write -> fifth stalled until first mem_ready; then accepted, wb_count returns to 4.
REQ-033 Write 0x0000020/D1 then 0x0000020/D2 before drain -> wb_count=1; memory sees exactly one write with D2.
REQ-034 Buffer holds 0x0000030/D3, then c_read 0x0000030 -> c_rdata=D3, no mem_read issued.
REQ-035 Buffer holds 0x0000040, in M_WR; c_read 0x0000050 -> mem_read 0x0000050 only after the write's mem_ready; c_rdata=mem_rdata.
REQ-036 proc_reset during M_RD with 3 entries -> next cycle all outputs at reset values, wb_count=0, no c_ready.

Source files
------------

// File: rtl/write_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : write_buffer_if
//  Description : Cache-side and memory-side bus bundle for the write buffer,
//                including the buffer occupancy status outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface write_buffer_if #(
    parameter int PTR_W = 2
);
    // cache side
    logic               c_read;
    logic               c_write;
    logic [27:0]        c_addr;
    logic [127:0]       c_wdata;
    logic [127:0]       c_rdata;
    logic               c_ready;
    // memory side
    logic               mem_read;
    logic               mem_write;
    logic [27:0]        mem_addr;
    logic [127:0]       mem_wdata;
    logic [127:0]       mem_rdata;
    logic               mem_ready;
    // status
    logic [PTR_W:0]     wb_count;
    logic               wb_empty;

    // the write buffer itself
    modport slave (
        input  c_read, c_write, c_addr, c_wdata, mem_rdata, mem_ready,
        output c_rdata, c_ready, mem_read, mem_write, mem_addr, mem_wdata,
               wb_count, wb_empty
    );

    // cache plus memory environment around the buffer
    modport master (
        output c_read, c_write, c_addr, c_wdata, mem_rdata, mem_ready,
        input  c_rdata, c_ready, mem_read, mem_write, mem_addr, mem_wdata,
               wb_count, wb_empty
    );
endinterface
`default_nettype wire

// File: rtl/write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : write_buffer
//  Description : Circular write-back buffer between a cache and memory.
//                Coalesces writes to queued lines, forwards reads from the
//                buffer, and lets read misses overtake queued writes.
//  Revision    : 1.0  initial release
// ============================================================================
module write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk,
    input  logic                proc_reset,
    write_buffer_if.slave       bus
);

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_RD   = 2'd1,
        M_WR   = 2'd2
    } mem_state_t;

    localparam logic [PTR_W:0]   c_FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_CNT_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE    = PTR_W'(1);

    // buffer storage
    logic [DEPTH-1:0]   r_valid;
    logic [27:0]        r_addr [DEPTH];
    logic [127:0]       r_data [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W:0]     r_count;

    // memory port
    mem_state_t         r_state;
    mem_state_t         w_state_nxt;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [27:0]        r_mem_addr;
    logic [127:0]       r_mem_wdata;

    // cache response and outstanding read miss
    logic               r_c_ready;
    logic [127:0]       r_c_rdata;
    logic               r_rd_pend;
    logic [27:0]        r_rd_addr;

    // decoded request handling
    logic               w_sample;
    logic               w_rd_hit;
    logic [PTR_W-1:0]   w_rd_idx;
    logic               w_wr_hit;
    logic [PTR_W-1:0]   w_wr_idx;
    logic               w_head_busy;
    logic               w_start_wr;
    logic               w_coalesce;
    logic               w_push;
    logic               w_fwd;
    logic               w_rd_miss_now;
    logic               w_pop;
    logic               w_rd_done;

    // New requests are only looked at when no response is due this cycle and
    // no read miss is still being serviced.
    assign w_sample      = !r_c_ready && !r_rd_pend;
    assign w_coalesce    = w_sample && bus.c_write && w_wr_hit;
    assign w_push        = w_sample && bus.c_write && !w_wr_hit && (r_count < c_FULL_COUNT);
    assign w_fwd         = w_sample && bus.c_read && !bus.c_write && w_rd_hit;
    assign w_rd_miss_now = w_sample && bus.c_read && !bus.c_write && !w_rd_hit;
    assign w_pop         = (r_state == M_WR) && bus.mem_ready;
    assign w_rd_done     = (r_state == M_RD) && bus.mem_ready;

    // The head entry is off limits for coalescing while it is being written,
    // including the edge on which its address/data are latched for memory.
    assign w_head_busy   = (r_state == M_WR) || w_start_wr;

    // Youngest valid match for reads; in-flight entry is still a valid source.
    always_comb begin : p_rd_lookup
        logic [PTR_W-1:0] v_idx;
        v_idx    = '0;
        w_rd_hit = 1'b0;
        w_rd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_head + PTR_W'(i);
            if (r_valid[v_idx] && (r_addr[v_idx] == bus.c_addr)) begin
                w_rd_hit = 1'b1;
                w_rd_idx = v_idx;
            end
        end
    end

    // Youngest valid match for writes, skipping the entry headed to memory.
    always_comb begin : p_wr_lookup
        logic [PTR_W-1:0] v_idx;
        v_idx    = '0;
        w_wr_hit = 1'b0;
        w_wr_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_head + PTR_W'(i);
            if (r_valid[v_idx] && (r_addr[v_idx] == bus.c_addr) &&
                !((v_idx == r_head) && w_head_busy)) begin
                w_wr_hit = 1'b1;
                w_wr_idx = v_idx;
            end
        end
    end

    // Memory port next state: read misses win over draining queued writes.
    always_comb begin
        w_state_nxt = r_state;
        w_start_wr  = 1'b0;
        case (r_state)
            M_IDLE: begin
                if (r_rd_pend || w_rd_miss_now) begin
                    w_state_nxt = M_RD;
                end else if (r_count != '0) begin
                    w_state_nxt = M_WR;
                    w_start_wr  = 1'b1;
                end
            end
            M_RD, M_WR: begin
                if (bus.mem_ready) begin
                    w_state_nxt = M_IDLE;
                end
            end
            default: w_state_nxt = M_IDLE;
        endcase
    end

    // Memory port state and registered request outputs.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state     <= M_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_read  <= (w_state_nxt == M_RD);
            r_mem_write <= (w_state_nxt == M_WR);
            if ((r_state == M_IDLE) && (w_state_nxt == M_RD)) begin
                r_mem_addr <= r_rd_pend ? r_rd_addr : bus.c_addr;
            end else if (w_start_wr) begin
                r_mem_addr  <= r_addr[r_head];
                r_mem_wdata <= r_data[r_head];
            end
        end
    end

    // Cache response: one registered c_ready per request.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_c_ready <= 1'b0;
            r_c_rdata <= '0;
            r_rd_pend <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_c_ready <= w_coalesce || w_push || w_fwd || w_rd_done;
            if (w_fwd) begin
                r_c_rdata <= r_data[w_rd_idx];
            end else if (w_rd_done) begin
                r_c_rdata <= bus.mem_rdata;
            end
            if (w_rd_miss_now) begin
                r_rd_pend <= 1'b1;
                r_rd_addr <= bus.c_addr;
            end else if (w_rd_done) begin
                r_rd_pend <= 1'b0;
            end
        end
    end

    // Queue bookkeeping: valid bits, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_ONE;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= bus.c_addr;
            r_data[r_tail] <= bus.c_wdata;
        end
        if (w_coalesce) begin
            r_data[w_wr_idx] <= bus.c_wdata;
        end
    end

    assign bus.c_ready   = r_c_ready;
    assign bus.c_rdata   = r_c_rdata;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.wb_count  = r_count;
    assign bus.wb_empty  = (r_count == '0);

endmodule
`default_nettype wire
